// File: rtl/blk_33c9ae_pkg.sv
// Shared definitions for the m_axi write burst splitter.
package blk_33c9ae_pkg;

  // AW splitter states
  typedef enum logic {IDLE, SPLIT} state_t;

  // Burst-length FIFO entry: beats per burst, 1..256
  localparam int FIFO_W = 9;

  // Hard AXI4 ceiling on beats per burst; MAX_BURST_LEN is clamped to this
  localparam int AXI_MAX_BURST = 256;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  // Width that holds beats-to-boundary in bytes before the divide (0..BOUNDARY)
  function automatic int btb_width(input int boundary);
    return $clog2(boundary) + 1;
  endfunction

endpackage

// File: rtl/blk_33c9ae_burst_fifo.sv
// Burst-length FIFO: first-word fall-through, registered full/empty flags.
module blk_33c9ae_burst_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt, cnt_nxt;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  // next occupancy, used to register the flags
  always_comb begin
    cnt_nxt = cnt;
    if (do_push && !do_pop)      cnt_nxt = cnt + (PW+1)'(1);
    else if (!do_push && do_pop) cnt_nxt = cnt - (PW+1)'(1);
  end

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // pointers, occupancy and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (PW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/blk_33c9ae.sv
// Splits user write requests into AXI bursts (length cap, no BOUNDARY
// crossing) and regenerates WLAST on the pass-through W stream.
module blk_33c9ae
  import blk_33c9ae_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int BOUNDARY      = 4096,
  parameter int MAXREQS       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   in_REQ_ADDR,
  input  logic [LEN_WIDTH-1:0]    in_REQ_LEN,
  input  logic                    in_REQ_VALID,
  output logic                    out_REQ_READY,
  input  logic [DATA_WIDTH-1:0]   in_WDATA,
  input  logic [DATA_WIDTH/8-1:0] in_WSTRB,
  input  logic                    in_WVALID,
  output logic                    out_WREADY,
  output logic [ADDR_WIDTH-1:0]   out_AWADDR,
  output logic [7:0]              out_AWLEN,
  output logic                    out_AWVALID,
  input  logic                    in_AWREADY,
  output logic [DATA_WIDTH-1:0]   out_WDATA,
  output logic [DATA_WIDTH/8-1:0] out_WSTRB,
  output logic                    out_WLAST,
  output logic                    out_WVALID,
  input  logic                    in_WREADY
);
  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int BSH   = $clog2(BYTES);
  localparam int BW    = $clog2(BOUNDARY);
  localparam int BTB_W = btb_width(BOUNDARY);
  localparam int CW    = LEN_WIDTH + 1;
  localparam int MAXB  = (MAX_BURST_LEN > AXI_MAX_BURST) ? AXI_MAX_BURST : MAX_BURST_LEN;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remain;
  logic [BTB_W-1:0]      to_bnd;
  logic [CW-1:0]         beats;
  logic                  aw_hs, w_hs;
  logic                  full, empty;
  logic [FIFO_W-1:0]     head;
  logic [7:0]            beat_cnt;

  // beats left before the next BOUNDARY multiple
  assign to_bnd = (BTB_W'(BOUNDARY) - {1'b0, cur_addr[BW-1:0]}) >> BSH;

  // burst size: min of remaining, length cap and distance to boundary
  always_comb begin
    beats = {1'b0, remain};
    if (beats > CW'(MAXB))   beats = CW'(MAXB);
    if (beats > CW'(to_bnd)) beats = CW'(to_bnd);
  end

  assign out_REQ_READY = (state == IDLE);
  // AWVALID looks only at the registered full flag, so a same-cycle pop
  // does not open a slot
  assign out_AWVALID   = (state == SPLIT) & ~full;
  assign out_AWADDR    = (state == SPLIT) ? cur_addr : '0;
  // beats==256 wraps to 8'hFF, which is the correct AWLEN
  assign out_AWLEN     = (state == SPLIT) ? (beats[7:0] - 8'd1) : '0;
  assign aw_hs         = out_AWVALID & in_AWREADY;

  // request acceptance and burst walking
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_addr <= '0;
      remain   <= '0;
    end else begin
      case (state)
        IDLE: if (in_REQ_VALID && in_REQ_LEN != '0) begin
          cur_addr <= in_REQ_ADDR;
          remain   <= in_REQ_LEN;
          state    <= SPLIT;
        end
        SPLIT: if (aw_hs) begin
          cur_addr <= cur_addr + ADDR_WIDTH'(beats << BSH);
          remain   <= remain - beats[LEN_WIDTH-1:0];
          if ({1'b0, remain} == beats) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  blk_33c9ae_burst_fifo #(.W(FIFO_W), .DEPTH(MAXREQS)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (aw_hs),
    .din   (beats[FIFO_W-1:0]),
    .pop   (w_hs & out_WLAST),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // W beats are held off until their burst has been issued on AW
  assign out_WVALID = in_WVALID & ~empty;
  assign out_WREADY = in_WREADY & ~empty;
  assign out_WDATA  = in_WDATA;
  assign out_WSTRB  = in_WSTRB;
  assign out_WLAST  = ~empty & ({1'b0, beat_cnt} == head - FIFO_W'(1));
  assign w_hs       = in_WVALID & in_WREADY & ~empty;

  // beat position within the burst at the FIFO head
  always_ff @(posedge clk) begin
    if (reset)          beat_cnt <= '0;
    else if (w_hs) begin
      if (out_WLAST)    beat_cnt <= '0;
      else              beat_cnt <= beat_cnt + 8'd1;
    end
  end

endmodule
